apb_slave_mem_v2: RTL and testbench

Parametrised APB4 completer that replaces the fixed 16-word APB slave memory. Features:
- Configurable data width, depth and base address.
- Programmable wait states.
- Byte-lane write strobes.
- Address-range error response.
- Clean abort handling.

It sits behind the APB interconnect as a scratch/config RAM and is the model the directed APB testbenches target.

---
 rtl/apb_slave_mem_v2_pkg.sv | 34 +++
 rtl/apb_slave_mem_v2_mem_bank.sv | 43 ++++
 rtl/apb_slave_mem_v2.sv | 155 +++++++++++++++
 tb/tb_apb_slave_mem_v2.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_mem_v2_pkg.sv
// Shared types and helpers for the APB4 scratch memory: FSM state encoding,
// protection-bit positions and the byte-lane merge used on writes.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_state_e;

    localparam int PROT_PRIV_BIT  = 0;
    localparam int PROT_NSEC_BIT  = 1;
    localparam int PROT_INSTR_BIT = 2;

    // Widest supported data path; callers zero-extend into it and truncate the result.
    localparam int MERGE_W = 256;
    localparam int MERGE_B = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] wdata,
        input logic [MERGE_B-1:0] strb
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int b = 0; b < MERGE_B; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_slave_mem_v2_mem_bank.sv
// Word-addressed register array with synchronous clear, per-lane writes and a
// registered read port whose output drops to zero whenever no read is issued.
module apb_mem_bank
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_STRB  = DATA_WIDTH / 8,
    parameter int MEM_DEPTH  = 16,
    parameter int IDX_W      = 4
) (
    input  logic                  clk,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      widx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_STRB-1:0]  strb_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      ridx_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[widx_i] <= DATA_WIDTH'(byte_merge(MERGE_W'(mem_q[widx_i]),
                                                        MERGE_W'(wdata_i),
                                                        MERGE_B'(strb_i)));
            end
            rdata_q <= re_i ? mem_q[ridx_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_slave_mem_v2.sv
// APB4 completer fronting a scratch RAM with programmable wait states and range errors.
// Define APB_PROT_CHECK_EN to enable protection-attribute (prot) access errors.
module apb_slave_mem_v2
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DATA_STRB   = DATA_WIDTH / 8,
    parameter int                    MEM_DEPTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h0000_1000,
    parameter int                    WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  prst,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [2:0]            prot,
    input  logic                  pwrite,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_STRB-1:0]  pstrb,
    output logic                  pready,
    output logic                  slverr,
    output logic [DATA_WIDTH-1:0] prdata
);

    localparam int                    IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0]            LAST_CNT = 4'(WAIT_STATES - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);

    apb_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  wr_q, err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_STRB-1:0]  strb_q;
    logic                  pready_q, slverr_q;

    logic                  setup, capture, in_range, live_err;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      live_idx, bank_ridx;
    logic                  eff_wr, eff_err, bank_we, bank_re;
    logic                  unused_prot;

    assign setup    = psel & ~penable;
    assign capture  = setup & ((state_q == IDLE) | (state_q == DONE));
    assign offset   = paddr - BASE_ADDR;
    // The lower-bound test keeps addresses below BASE_ADDR from wrapping into range.
    assign in_range = (paddr >= BASE_ADDR) && (offset < DEPTH_A);
    assign live_idx = offset[IDX_W-1:0];

`ifdef APB_PROT_CHECK_EN
    assign live_err = !in_range
                    || (prot[PROT_NSEC_BIT] && (live_idx >= IDX_W'(MEM_DEPTH / 2)))
                    || (pwrite && !prot[PROT_PRIV_BIT] && (live_idx == '0));
    assign unused_prot = prot[PROT_INSTR_BIT];
`else
    assign live_err    = !in_range;
    assign unused_prot = ^{prot[PROT_INSTR_BIT], prot[PROT_NSEC_BIT], prot[PROT_PRIV_BIT]};
`endif

    always_ff @(posedge clk) begin
        if (prst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = (WAIT_STATES == 0) ? DONE : ACCESS;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (setup) begin
                    state_d = (WAIT_STATES == 0) ? DONE : ACCESS;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A transfer captured this cycle with zero wait states reads from the live bus.
    always_comb begin
        eff_wr    = capture ? pwrite   : wr_q;
        eff_err   = capture ? live_err : err_q;
        bank_ridx = capture ? live_idx : idx_q;
        bank_re   = (state_d == DONE) && !eff_wr && !eff_err;
        bank_we   = (state_q == DONE) && wr_q && !err_q;
    end

    always_ff @(posedge clk) begin
        if (prst) begin
            cnt_q    <= '0;
            pready_q <= 1'b0;
            slverr_q <= 1'b0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            pready_q <= (state_d == DONE);
            slverr_q <= (state_d == DONE) && eff_err;
            if (capture) begin
                idx_q   <= live_idx;
                wr_q    <= pwrite;
                err_q   <= live_err;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
            end
        end
    end

    apb_mem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_STRB  (DATA_STRB),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk     (clk),
        .clr_i   (prst),
        .we_i    (bank_we),
        .widx_i  (idx_q),
        .wdata_i (wdata_q),
        .strb_i  (strb_q),
        .re_i    (bank_re),
        .ridx_i  (bank_ridx),
        .rdata_o (prdata)
    );

    assign pready = pready_q;
    assign slverr = slverr_q;

endmodule

// File: tb/tb_apb_slave_mem_v2.sv
// Directed bench for apb_slave_mem_v2: a 2-wait-state instance and a zero-wait instance
// share one APB bus; each has its own psel.
module tb_apb_slave_mem_v2;

    localparam logic [31:0] B = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        prst;
    logic [31:0] paddr;
    logic [2:0]  prot;
    logic        pwrite, penable, psel0, psel1;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready0, slverr0, pready1, slverr1;
    logic [31:0] prdata0, prdata1;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    logic [31:0] shadow [16];

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vt [12];

    always #5 clk = ~clk;

    apb_slave_mem_v2 #(.WAIT_STATES(2)) dut0 (
        .clk(clk), .prst(prst), .paddr(paddr), .prot(prot), .pwrite(pwrite),
        .psel(psel0), .penable(penable), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready0), .slverr(slverr0), .prdata(prdata0)
    );

    apb_slave_mem_v2 #(.WAIT_STATES(0)) dut1 (
        .clk(clk), .prst(prst), .paddr(paddr), .prot(prot), .pwrite(pwrite),
        .psel(psel1), .penable(penable), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready1), .slverr(slverr1), .prdata(prdata1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Starts at #1 after a rising edge, returns at #1 after the completing edge.
    task automatic apb_xfer(input int which, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                            input logic chain, output logic [31:0] rd, output logic er,
                            output int nacc);
        logic rdy;
        paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; prot = pr; penable = 1'b0;
        if (which == 1) psel1 = 1'b1; else psel0 = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        pwdata  = ~wd;
        pstrb   = ~st;
        nacc = 0; rd = '0; er = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            rdy = (which == 1) ? pready1 : pready0;
            if (rdy) begin
                nacc = k;
                rd   = (which == 1) ? prdata1 : prdata0;
                er   = (which == 1) ? slverr1 : slverr0;
                break;
            end
            chk("wait_slverr", {31'b0, (which == 1) ? slverr1 : slverr0}, 32'h0);
            chk("wait_prdata", (which == 1) ? prdata1 : prdata0, 32'h0);
            @(posedge clk); #1;
        end
        if (nacc == 0) chk("pready_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        if (!chain) begin
            psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, d;
        logic        er;
        int          n;

        prst = 1'b1; paddr = '0; prot = '0; pwrite = 1'b0; penable = 1'b0;
        psel0 = 1'b0; psel1 = 1'b0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge clk);
        #1 prst = 1'b0;
        @(negedge clk);
        chk("rst_pready0", {31'b0, pready0}, 32'h0);
        chk("rst_slverr0", {31'b0, slverr0}, 32'h0);
        chk("rst_prdata0", prdata0, 32'h0);
        chk("rst_pready1", {31'b0, pready1}, 32'h0);
        chk("rst_prdata1", prdata1, 32'h0);
        @(posedge clk); #1;

        // Full write then read-back of every word.
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            shadow[i] = d;
            exp_q.push_back(d);
            apb_xfer(0, B + i, 1'b1, d, 4'hF, 3'b001, 1'b0, rd, er, n);
            chk("fill_wait", n, 3);
            chk("fill_err", {31'b0, er}, 32'h0);
        end
        for (int i = 0; i < 16; i++) begin
            apb_xfer(0, B + i, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0, rd, er, n);
            chk("readback_data", rd, exp_q.pop_front());
            chk("readback_wait", n, 3);
            chk("readback_err", {31'b0, er}, 32'h0);
        end

        vt[0]  = '{B + 3,         1'b1, 32'hAABBCCDD, 4'hF,    32'h0, 1'b0};
        vt[1]  = '{B + 3,         1'b1, 32'h11223344, 4'b0101, 32'h0, 1'b0};
        vt[2]  = '{B + 3,         1'b0, 32'h0,        4'h0,    32'hAA22CC44, 1'b0};
        vt[3]  = '{B + 16,        1'b1, 32'hDEADBEEF, 4'hF,    32'h0, 1'b1};
        vt[4]  = '{B - 1,         1'b0, 32'h0,        4'hF,    32'h0, 1'b1};
        vt[5]  = '{B + 15,        1'b0, 32'h0,        4'hF,    shadow[15], 1'b0};
        vt[6]  = '{B + 7,         1'b1, 32'hFFFFFFFF, 4'h0,    32'h0, 1'b0};
        vt[7]  = '{B + 7,         1'b0, 32'h0,        4'hF,    shadow[7], 1'b0};
        vt[8]  = '{B + 0,         1'b1, 32'h12345678, 4'b1000, 32'h0, 1'b0};
        vt[9]  = '{B + 0,         1'b0, 32'h0,        4'hF,    {8'h12, shadow[0][23:0]}, 1'b0};
        vt[10] = '{32'h0,         1'b0, 32'h0,        4'hF,    32'h0, 1'b1};
        vt[11] = '{32'hFFFF_FFFF, 1'b0, 32'h0,        4'hF,    32'h0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            apb_xfer(0, vt[i].addr, vt[i].wr, vt[i].wdata, vt[i].strb, 3'b001, 1'b0, rd, er, n);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vt[i].exp_err});
            chk($sformatf("vec%0d_wait", i), n, 3);
        end

        // penable without a setup phase must be ignored.
        psel0 = 1'b1; penable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("noset_pready", {31'b0, pready0}, 32'h0);
            @(posedge clk); #1;
        end
        psel0 = 1'b0; penable = 1'b0;
        apb_xfer(0, B + 3, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0, rd, er, n);
        chk("noset_after_rd", rd, 32'hAA22CC44);

        // Abort: psel dropped in the second access cycle of a write.
        paddr = B + 5; pwrite = 1'b1; pwdata = 32'hDEADBEEF; pstrb = 4'hF; prot = 3'b001;
        psel0 = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk); chk("abort_c1_pready", {31'b0, pready0}, 32'h0);
        @(posedge clk); #1 psel0 = 1'b0; penable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_pready", {31'b0, pready0}, 32'h0);
        end
        @(posedge clk); #1;
        apb_xfer(0, B + 5, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0, rd, er, n);
        chk("abort_mem5", rd, shadow[5]);

        // Protection attributes.
        apb_xfer(0, B + 12, 1'b1, 32'h01020304, 4'hF, 3'b001, 1'b0, rd, er, n);
        chk("prot_pre_err", {31'b0, er}, 32'h0);
        apb_xfer(0, B + 12, 1'b1, 32'h5A5A5A5A, 4'hF, 3'b010, 1'b0, rd, er, n);
`ifdef APB_PROT_CHECK_EN
        chk("prot_nsec_hi_err", {31'b0, er}, 32'h1);
        apb_xfer(0, B + 12, 1'b0, 32'h0, 4'hF, 3'b000, 1'b0, rd, er, n);
        chk("prot_hi_kept", rd, 32'h01020304);
        apb_xfer(0, B + 0, 1'b1, 32'h0, 4'hF, 3'b000, 1'b0, rd, er, n);
        chk("prot_unpriv_idx0_err", {31'b0, er}, 32'h1);
`else
        chk("prot_ignored_err", {31'b0, er}, 32'h0);
        apb_xfer(0, B + 12, 1'b0, 32'h0, 4'hF, 3'b000, 1'b0, rd, er, n);
        chk("prot_ignored_rd", rd, 32'h5A5A5A5A);
`endif
        apb_xfer(0, B + 2, 1'b1, 32'h5A5A5A5A, 4'hF, 3'b010, 1'b0, rd, er, n);
        chk("prot_lo_err", {31'b0, er}, 32'h0);
        apb_xfer(0, B + 2, 1'b0, 32'h0, 4'hF, 3'b000, 1'b0, rd, er, n);
        chk("prot_lo_rd", rd, 32'h5A5A5A5A);

        // Reset during the second access cycle of a write.
        paddr = B + 6; pwrite = 1'b1; pwdata = 32'h00000077; pstrb = 4'hF; prot = 3'b001;
        psel0 = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 prst = 1'b1;
        @(posedge clk); #1 prst = 1'b0; psel0 = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("midrst_pready", {31'b0, pready0}, 32'h0);
        chk("midrst_slverr", {31'b0, slverr0}, 32'h0);
        chk("midrst_prdata", prdata0, 32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i += 5) begin
            apb_xfer(0, B + i, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0, rd, er, n);
            chk("midrst_cleared", rd, 32'h0);
        end
        apb_xfer(0, B + 6, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0, rd, er, n);
        chk("midrst_mem6", rd, 32'h0);

        // Zero wait states, back-to-back write then read.
        apb_xfer(1, B + 1, 1'b1, 32'hCAFEF00D, 4'hF, 3'b001, 1'b1, rd, er, n);
        chk("w0_wr_wait", n, 1);
        chk("w0_wr_err", {31'b0, er}, 32'h0);
        apb_xfer(1, B + 1, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0, rd, er, n);
        chk("w0_rd_wait", n, 1);
        chk("w0_rd_data", rd, 32'hCAFEF00D);
        apb_xfer(1, B + 16, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0, rd, er, n);
        chk("w0_range_err", {31'b0, er}, 32'h1);
        chk("w0_range_rd", rd, 32'h0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
